// File: rtl/pipe_control_unit.sv
// pipe_control_unit: D-stage decode, ID/EX -> EX/MEM -> MEM/WB control pipeline and hazard unit for the 5-stage RV32I core.
// Build option: define CTRL_FWD_EN to carry Rs1E/Rs2E and drive ForwardAE/ForwardBE; otherwise dependents stall in D.
module pipe_control_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     InstrD,
  input  logic                      BranchCondE,
  input  logic                      MemReadyM,
  output logic [2:0]                ImmSrcD,
  output logic [3:0]                ALUCtrlE,
  output logic                      ALUSrcE,
  output logic [1:0]                PCSrcE,
  output logic                      MemWriteM,
  output logic [2:0]                modeBUM,
  output logic                      RegWriteM,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic                      RegWriteW,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic [1:0]                ResultSrcW,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE
);

  localparam int unsigned RA = REG_ADDR_WIDTH;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          load;
    logic [1:0]    pc_kind;
    logic [1:0]    result_src;
    logic [2:0]    mode_bu;
    logic          alu_src;
    logic [3:0]    alu_ctrl;
    logic [RA-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          load;
    logic [1:0]    result_src;
    logic [2:0]    mode_bu;
    logic [RA-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic          reg_write;
    logic [1:0]    result_src;
    logic [RA-1:0] rd;
  } wb_t;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [RA-1:0] rd_d, rs1_d, rs2_d;
  logic          unused_instr;

  assign opcode       = InstrD[6:0];
  assign funct3       = InstrD[14:12];
  assign funct7b5     = InstrD[30];
  assign rd_d         = RA'(InstrD[11:7]);
  assign rs1_d        = RA'(InstrD[19:15]);
  assign rs2_d        = RA'(InstrD[24:20]);
  assign unused_instr = ^{InstrD[DATA_WIDTH-1:31], InstrD[29:25]};

  ex_t        dec;
  logic [1:0] alu_op;
  logic       use_rs1, use_rs2;

  // Main decoder: opcode -> control bundle, immediate select and source usage
  always_comb begin
    dec     = '0;
    ImmSrcD = 3'b000;
    alu_op  = 2'b00;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1; alu_op = 2'b10; use_rs2 = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; alu_op = 2'b10;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.load = 1'b1; dec.result_src = 2'b01;
      end
      OP_STORE: begin
        ImmSrcD = 3'b001; dec.mem_write = 1'b1; dec.alu_src = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ImmSrcD = 3'b010; dec.pc_kind = 2'b10; alu_op = 2'b01; use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ImmSrcD = 3'b011; dec.reg_write = 1'b1; dec.alu_src = 1'b1; use_rs1 = 1'b0;
      end
      OP_JAL: begin
        ImmSrcD = 3'b100; dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.pc_kind = 2'b01;
        use_rs1 = 1'b0;
      end
      OP_JALR: begin
        ImmSrcD = 3'b101; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b10;
        dec.pc_kind = 2'b11;
      end
      default: ;
    endcase
    dec.rd = dec.reg_write ? rd_d : '0;

    if (dec.load || dec.mem_write) begin
      case (funct3)
        3'b000:  dec.mode_bu = 3'b011;
        3'b001:  dec.mode_bu = 3'b010;
        3'b010:  dec.mode_bu = 3'b001;
        3'b100:  dec.mode_bu = dec.load ? 3'b101 : 3'b000;
        3'b101:  dec.mode_bu = dec.load ? 3'b100 : 3'b000;
        default: dec.mode_bu = 3'b000;
      endcase
    end

    case (alu_op)
      2'b00: dec.alu_ctrl = ALU_ADD;
      2'b01: dec.alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  dec.alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_ctrl = ALU_SLL;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b101:  dec.alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  ex_t  ex_q;
  mem_t mem_q;
  wb_t  wb_q;

  logic freeze, taken, hazard_d;

  function automatic logic src_hit(input logic used, input logic [RA-1:0] rs,
                                   input logic wr, input logic [RA-1:0] rd);
    return used && wr && (rd != '0) && (rd == rs);
  endfunction

  assign freeze = !MemReadyM && (mem_q.mem_write || mem_q.load);
  // A redirect seen during a freeze is re-evaluated once E is released
  assign taken  = !freeze && ((ex_q.pc_kind == 2'b01) || (ex_q.pc_kind == 2'b11) ||
                              (ex_q.pc_kind == 2'b10 && BranchCondE));
  assign PCSrcE = taken ? ex_q.pc_kind : 2'b00;

`ifdef CTRL_FWD_EN
  assign hazard_d = src_hit(use_rs1, rs1_d, ex_q.load, ex_q.rd) ||
                    src_hit(use_rs2, rs2_d, ex_q.load, ex_q.rd);
`else
  assign hazard_d = src_hit(use_rs1, rs1_d, ex_q.reg_write,  ex_q.rd)  ||
                    src_hit(use_rs1, rs1_d, mem_q.reg_write, mem_q.rd) ||
                    src_hit(use_rs1, rs1_d, wb_q.reg_write,  wb_q.rd)  ||
                    src_hit(use_rs2, rs2_d, ex_q.reg_write,  ex_q.rd)  ||
                    src_hit(use_rs2, rs2_d, mem_q.reg_write, mem_q.rd) ||
                    src_hit(use_rs2, rs2_d, wb_q.reg_write,  wb_q.rd);
`endif

  // Hazard priority: memory freeze, then redirect flush, then data-hazard bubble
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (taken) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (hazard_d) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      ex_q             <= FlushE ? '0 : dec;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.load       <= ex_q.load;
      mem_q.result_src <= ex_q.result_src;
      mem_q.mode_bu    <= ex_q.mode_bu;
      mem_q.rd         <= ex_q.rd;
      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.result_src  <= mem_q.result_src;
      wb_q.rd          <= mem_q.rd;
    end
  end

`ifdef CTRL_FWD_EN
  logic [RA-1:0] rs1_e, rs2_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_e <= '0;
      rs2_e <= '0;
    end else if (!freeze) begin
      rs1_e <= FlushE ? '0 : rs1_d;
      rs2_e <= FlushE ? '0 : rs2_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [RA-1:0] rs);
    if (mem_q.reg_write && mem_q.rd != '0 && mem_q.rd == rs) return 2'b10;
    if (wb_q.reg_write && wb_q.rd != '0 && wb_q.rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(rs1_e);
  assign ForwardBE = fwd_sel(rs2_e);
`else
  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;
`endif

  assign ALUCtrlE   = ex_q.alu_ctrl;
  assign ALUSrcE    = ex_q.alu_src;
  assign MemWriteM  = mem_q.mem_write;
  assign modeBUM    = mem_q.mode_bu;
  assign RegWriteM  = mem_q.reg_write;
  assign RdM        = mem_q.rd;
  assign RegWriteW  = wb_q.reg_write;
  assign RdW        = wb_q.rd;
  assign ResultSrcW = wb_q.result_src;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed and random checks of pipe_control_unit against an instruction-level pipeline model.
// Expectations follow CTRL_FWD_EN the same way the design does.
module tb_pipe_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

`ifdef CTRL_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BAD} kind_e;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d;
  logic        branch_cond, mem_ready;
  logic [2:0]  ImmSrcD;
  logic [3:0]  ALUCtrlE;
  logic        ALUSrcE;
  logic [1:0]  PCSrcE;
  logic        MemWriteM;
  logic [2:0]  modeBUM;
  logic        RegWriteM, RegWriteW;
  logic [4:0]  RdM, RdW;
  logic [1:0]  ResultSrcW;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;

  pipe_control_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .InstrD(instr_d), .BranchCondE(branch_cond), .MemReadyM(mem_ready),
    .ImmSrcD(ImmSrcD), .ALUCtrlE(ALUCtrlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE),
    .MemWriteM(MemWriteM), .modeBUM(modeBUM), .RegWriteM(RegWriteM), .RdM(RdM),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: instruction word held in each stage; a bubble is the all-zero word
  logic [31:0] e_w, m_w, w_w;
  logic [31:0] prog[$];
  logic        rand_en;
  logic        m_frz, m_tk, m_stall, m_flushd, m_flushe;

  function automatic kind_e kind_of(logic [31:0] w);
    case (w[6:0])
      OP_R:      return K_R;
      OP_I:      return K_I;
      OP_LOAD:   return K_LOAD;
      OP_STORE:  return K_STORE;
      OP_BRANCH: return K_BR;
      OP_LUI:    return K_LUI;
      OP_AUIPC:  return K_AUIPC;
      OP_JAL:    return K_JAL;
      OP_JALR:   return K_JALR;
      default:   return K_BAD;
    endcase
  endfunction

  function automatic logic writes(kind_e k);
    return k inside {K_R, K_I, K_LOAD, K_LUI, K_AUIPC, K_JAL, K_JALR};
  endfunction
  function automatic logic uses_rs1(kind_e k);
    return !(k inside {K_LUI, K_AUIPC, K_JAL});
  endfunction
  function automatic logic uses_rs2(kind_e k);
    return k inside {K_R, K_STORE, K_BR};
  endfunction

  function automatic logic [2:0] imm_src(kind_e k);
    case (k)
      K_STORE:        return 3'b001;
      K_BR:           return 3'b010;
      K_LUI, K_AUIPC: return 3'b011;
      K_JAL:          return 3'b100;
      K_JALR:         return 3'b101;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] pc_kind(kind_e k);
    return (k == K_BR) ? 2'b10 : (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] result_src(kind_e k);
    return (k == K_LOAD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic alu_src(kind_e k);
    return k inside {K_I, K_LOAD, K_STORE, K_LUI, K_AUIPC, K_JALR};
  endfunction

  // ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9
  function automatic logic [3:0] alu_ctrl(logic [31:0] w);
    kind_e k = kind_of(w);
    if (k == K_BR) return 4'd1;
    if (k != K_R && k != K_I) return 4'd0;
    case (w[14:12])
      3'd0:    return (k == K_R && w[30]) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return w[30] ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [2:0] mode_bu(logic [31:0] w);
    kind_e k = kind_of(w);
    if (k != K_LOAD && k != K_STORE) return 3'b000;
    case (w[14:12])
      3'd0:    return 3'b011;
      3'd1:    return 3'b010;
      3'd2:    return 3'b001;
      3'd4:    return (k == K_LOAD) ? 3'b101 : 3'b000;
      3'd5:    return (k == K_LOAD) ? 3'b100 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic dep(logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
`ifdef CTRL_FWD_EN
    return kind_of(e_w) == K_LOAD && e_w[11:7] == rs;
`else
    return (writes(kind_of(e_w)) && e_w[11:7] == rs) ||
           (writes(kind_of(m_w)) && m_w[11:7] == rs) ||
           (writes(kind_of(w_w)) && w_w[11:7] == rs);
`endif
  endfunction

`ifdef CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(logic [4:0] rs);
    if (rs != 5'd0 && writes(kind_of(m_w)) && m_w[11:7] == rs) return 2'b10;
    if (rs != 5'd0 && writes(kind_of(w_w)) && w_w[11:7] == rs) return 2'b01;
    return 2'b00;
  endfunction
`endif

  function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                      logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd  = 5'($urandom_range(0, 7));
    logic [4:0] rs1 = 5'($urandom_range(0, 7));
    logic [4:0] rs2 = 5'($urandom_range(0, 7));
    logic [2:0] f3  = 3'($urandom_range(0, 7));
    logic [6:0] f7  = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 9))
      0:       return enc(OP_R, rd, f3, rs1, rs2, f7);
      1:       return enc(OP_I, rd, f3, rs1, rs2, f7);
      2:       return enc(OP_LOAD, rd, f3, rs1, rs2, f7);
      3:       return enc(OP_STORE, rd, f3, rs1, rs2, f7);
      4:       return enc(OP_BRANCH, rd, f3, rs1, rs2, f7);
      5:       return enc(OP_LUI, rd, f3, rs1, rs2, f7);
      6:       return enc(OP_AUIPC, rd, f3, rs1, rs2, f7);
      7:       return enc(OP_JAL, rd, f3, rs1, rs2, f7);
      8:       return enc(OP_JALR, rd, 3'd0, rs1, rs2, f7);
      default: return enc(7'b1111111, rd, f3, rs1, rs2, f7);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current cycle and latch the model's hazard decisions
  task automatic check_all();
    kind_e kd, ke, km, kw;
    logic [1:0] pk, fa, fb;
    logic hz;
    kd = kind_of(instr_d);
    ke = kind_of(e_w);
    km = kind_of(m_w);
    kw = kind_of(w_w);
    m_frz    = !mem_ready && (km == K_LOAD || km == K_STORE);
    pk       = pc_kind(ke);
    m_tk     = !m_frz && (pk == 2'b01 || pk == 2'b11 || (pk == 2'b10 && branch_cond));
    hz       = (uses_rs1(kd) && dep(instr_d[19:15])) || (uses_rs2(kd) && dep(instr_d[24:20]));
    m_stall  = m_frz || (!m_tk && hz);
    m_flushd = !m_frz && m_tk;
    m_flushe = !m_frz && (m_tk || hz);
`ifdef CTRL_FWD_EN
    fa = fwd_sel(e_w[19:15]);
    fb = fwd_sel(e_w[24:20]);
`else
    fa = 2'b00;
    fb = 2'b00;
`endif
    chk("ImmSrcD",    32'(ImmSrcD),    32'(imm_src(kd)));
    chk("ALUCtrlE",   32'(ALUCtrlE),   32'(alu_ctrl(e_w)));
    chk("ALUSrcE",    32'(ALUSrcE),    32'(alu_src(ke)));
    chk("PCSrcE",     32'(PCSrcE),     32'(m_tk ? pk : 2'b00));
    chk("MemWriteM",  32'(MemWriteM),  32'(km == K_STORE));
    chk("modeBUM",    32'(modeBUM),    32'(mode_bu(m_w)));
    chk("RegWriteM",  32'(RegWriteM),  32'(writes(km)));
    if (writes(km)) chk("RdM", 32'(RdM), 32'(m_w[11:7]));
    chk("RegWriteW",  32'(RegWriteW),  32'(writes(kw)));
    if (writes(kw)) chk("RdW", 32'(RdW), 32'(w_w[11:7]));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(result_src(kw)));
    chk("StallF",     32'(StallF),     32'(m_stall));
    chk("StallD",     32'(StallD),     32'(m_stall));
    chk("FlushD",     32'(FlushD),     32'(m_flushd));
    chk("FlushE",     32'(FlushE),     32'(m_flushe));
    chk("ForwardAE",  32'(ForwardAE),  32'(fa));
    chk("ForwardBE",  32'(ForwardBE),  32'(fb));
  endtask

  // One clock: check, advance model and IF/ID as the surrounding datapath would, drive next inputs
  task automatic step();
    check_all();
    @(posedge clk);
    #1;
    if (!m_frz) begin
      w_w = m_w;
      m_w = e_w;
      e_w = m_flushe ? 32'd0 : instr_d;
    end
    if (m_flushd) instr_d = 32'd0;
    else if (!m_stall) begin
      if (prog.size() != 0) instr_d = prog.pop_front();
      else instr_d = rand_en ? rand_instr() : 32'd0;
    end
    if (rand_en) begin
      branch_cond = ($urandom_range(0, 1) != 0);
      mem_ready   = ($urandom_range(0, 3) != 0);
    end
    #1;
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  initial begin
    int cnt;
    int seen;
    rst = 1'b1; instr_d = 32'd0; branch_cond = 1'b0; mem_ready = 1'b1; rand_en = 1'b0;
    e_w = 32'd0; m_w = 32'd0; w_w = 32'd0;
    #12;
    check_all();
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_StallF",    32'(StallF),    32'd0);
    rst = 1'b0;
    #1;

    // Load-use: lw x5,0(x2) ; add x6,x5,x7
    prog.push_back(enc(OP_LOAD, 5'd5, 3'd2, 5'd2, 5'd0, 7'd0));
    prog.push_back(enc(OP_R, 5'd6, 3'd0, 5'd5, 5'd7, 7'd0));
    step();
    cnt = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (StallD === 1'b1 && FlushE === 1'b1) cnt++;
      if (RegWriteW === 1'b1 && RdW === 5'd6 && ResultSrcW === 2'b00) seen = 1;
      step();
    end
    chk("lu_stall_cycles", 32'(cnt), 32'(FWD ? 1 : 3));
    chk("lu_add_in_w",     32'(seen), 32'd1);
    drain();

    // Taken branch: beq x1,x2 with BranchCondE=1
    prog.push_back(enc(OP_BRANCH, 5'd8, 3'd0, 5'd1, 5'd2, 7'd0));
    step(); step();
    branch_cond = 1'b1; #1;
    chk("br_PCSrcE", 32'(PCSrcE), 32'd2);
    chk("br_FlushD", 32'(FlushD), 32'd1);
    chk("br_FlushE", 32'(FlushE), 32'd1);
    step();
    chk("br_after_PCSrcE", 32'(PCSrcE), 32'd0);
    chk("br_after_FlushD", 32'(FlushD), 32'd0);
    step();
    chk("br_bubble_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("br_bubble_MemWriteM", 32'(MemWriteM), 32'd0);
    branch_cond = 1'b0; #1;
    drain();

    // Store freeze: sw x4,0(x3) held in M for three cycles
    prog.push_back(enc(OP_STORE, 5'd0, 3'd2, 5'd3, 5'd4, 7'd0));
    step(); step(); step();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("frz_StallF",    32'(StallF),    32'd1);
      chk("frz_StallD",    32'(StallD),    32'd1);
      chk("frz_MemWriteM", 32'(MemWriteM), 32'd1);
      chk("frz_modeBUM",   32'(modeBUM),   32'd1);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("frz_release_StallF", 32'(StallF), 32'd0);
    chk("frz_release_MemWriteM", 32'(MemWriteM), 32'd1);
    step();
    chk("frz_retired_MemWriteM", 32'(MemWriteM), 32'd0);
    drain();

    // lbu x3,0(x1)
    prog.push_back(enc(OP_LOAD, 5'd3, 3'd4, 5'd1, 5'd0, 7'd0));
    step(); step(); step();
    chk("lbu_modeBUM", 32'(modeBUM), 32'd5);
    step();
    chk("lbu_RegWriteW",  32'(RegWriteW),  32'd1);
    chk("lbu_ResultSrcW", 32'(ResultSrcW), 32'd1);
    chk("lbu_RdW",        32'(RdW),        32'd3);
    drain();

    // add x1,x3,x4 ; add x2,x1,x1
    prog.push_back(enc(OP_R, 5'd1, 3'd0, 5'd3, 5'd4, 7'd0));
    prog.push_back(enc(OP_R, 5'd2, 3'd0, 5'd1, 5'd1, 7'd0));
    step();
    cnt = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (StallD === 1'b1) cnt++;
      if (ForwardAE === 2'b10 && ForwardBE === 2'b10) seen = 1;
      step();
    end
    chk("raw_stall_cycles", 32'(cnt),  32'(FWD ? 0 : 3));
    chk("raw_fwd_seen",     32'(seen), 32'(FWD));
    drain();

    // Random program, random branch outcomes and memory waits
    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0; mem_ready = 1'b1; branch_cond = 1'b0; #1;
    drain();

    // Reset mid-stream with a store in M
    prog.push_back(enc(OP_STORE, 5'd0, 3'd2, 5'd3, 5'd4, 7'd0));
    prog.push_back(enc(OP_R, 5'd7, 3'd0, 5'd1, 5'd2, 7'd0));
    step(); step(); step();
    chk("pre_rst_MemWriteM", 32'(MemWriteM), 32'd1);
    rst = 1'b1; e_w = 32'd0; m_w = 32'd0; w_w = 32'd0; instr_d = 32'd0; prog.delete(); #1;
    check_all();
    chk("mrst_MemWriteM", 32'(MemWriteM), 32'd0);
    chk("mrst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("mrst_hazards",   32'({StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE}), 32'd0);
    @(posedge clk); #2;
    check_all();
    rst = 1'b0; #1;
    prog.push_back(enc(OP_I, 5'd9, 3'd0, 5'd0, 5'd1, 7'd0));
    step();
    step(); step();
    chk("post_rst_not_yet_w", 32'(RegWriteW), 32'd0);
    step();
    chk("post_rst_RegWriteW", 32'(RegWriteW), 32'd1);
    chk("post_rst_RdW",       32'(RdW),       32'd9);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
